// File: rtl/load_unit.sv
// Memory-stage load engine: issues a word-aligned bus read, waits for ack or timeout,
// then returns the extended byte/halfword/word with a one-cycle valid pulse.
module load_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [2:0]  DEType,
    input  logic        Req,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        busy,
    output logic        valid,
    output logic [31:0] rdata,
    output logic [1:0]  err
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [2:0] TypeLw  = 3'b001;
    localparam logic [2:0] TypeLbu = 3'b010;
    localparam logic [2:0] TypeLb  = 3'b011;
    localparam logic [2:0] TypeLhu = 3'b100;
    localparam logic [2:0] TypeLh  = 3'b101;

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrAlign   = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  type_q, type_d;

    logic        align_ok;
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] extracted;

    always_comb begin
        unique case (DEType)
            TypeLw:         align_ok = (addr[1:0] == 2'b00);
            TypeLbu, TypeLb: align_ok = 1'b1;
            TypeLhu, TypeLh: align_ok = ~addr[0];
            default:        align_ok = 1'b0;
        endcase
    end

    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        half    = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (type_q)
            TypeLbu: extracted = {24'h0, shifted[7:0]};
            TypeLb:  extracted = {{24{shifted[7]}}, shifted[7:0]};
            TypeLhu: extracted = {16'h0, half};
            TypeLh:  extracted = {{16{half[15]}}, half};
            default: extracted = bus_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        valid_d    = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        off_d      = off_q;
        type_d     = type_q;

        // Flush wins over start, ack and timeout; result registers keep the last value.
        if (Req) begin
            state_d   = StIdle;
            bus_req_d = 1'b0;
            cnt_d     = 8'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (align_ok) begin
                            off_d      = addr[1:0];
                            type_d     = DEType;
                            bus_addr_d = {addr[31:2], 2'b00};
                            bus_req_d  = 1'b1;
                            cnt_d      = 8'h0;
                            state_d    = StWait;
                        end else begin
                            rdata_d = 32'h0;
                            err_d   = ErrAlign;
                            valid_d = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
                StWait: begin
                    if (bus_ack) begin
                        bus_req_d = 1'b0;
                        rdata_d   = extracted;
                        err_d     = ErrOk;
                        valid_d   = 1'b1;
                        state_d   = StDone;
                    end else if (cnt_q == CntLast) begin
                        bus_req_d = 1'b0;
                        rdata_d   = 32'h0;
                        err_d     = ErrTimeout;
                        valid_d   = 1'b1;
                        state_d   = StDone;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bus_req_q  <= 1'b0;
            bus_addr_q <= 32'h0;
            valid_q    <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 2'b00;
            cnt_q      <= 8'h0;
            off_q      <= 2'b00;
            type_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            type_q     <= type_d;
        end
    end

    assign bus_req  = bus_req_q;
    assign bus_addr = bus_addr_q;
    assign busy     = (state_q != StIdle);
    assign valid    = valid_q;
    assign rdata    = rdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: expected results are queued at issue and popped on valid.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [2:0]  DEType = 3'b000;
    logic        Req = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        busy;
    logic        valid;
    logic [31:0] rdata;
    logic [1:0]  err;

    load_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr      (addr),
        .DEType    (DEType),
        .Req       (Req),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .busy      (busy),
        .valid     (valid),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic [1:0]  er;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] last_rd = 32'h0;
    logic [1:0]  last_err = 2'b00;

    // Reference extraction; returns mis=1 for misaligned or invalid type.
    function automatic void model(input logic [2:0] t, input logic [31:0] a,
                                  input logic [31:0] d, output exp_t e, output logic mis);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*a[1:0] +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        mis = 1'b0;
        e.er = 2'b00;
        e.rd = 32'h0;
        case (t)
            3'd1: if (a[1:0] != 2'b00) mis = 1'b1; else e.rd = d;
            3'd2: e.rd = {24'h0, b};
            3'd3: e.rd = {{24{b[7]}}, b};
            3'd4: if (a[0]) mis = 1'b1; else e.rd = {16'h0, h};
            3'd5: if (a[0]) mis = 1'b1; else e.rd = {{16{h[15]}}, h};
            default: mis = 1'b1;
        endcase
        if (mis) begin
            e.rd = 32'h0;
            e.er = 2'b01;
        end
    endfunction

    // Drives one load; acks in WAIT cycle ack_k (0 = never). lat=0 means no valid seen.
    task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                           input int ack_k, output int lat, output int req_cycles,
                           output logic [31:0] got_rd, output logic [1:0] got_err,
                           output logic [31:0] got_addr);
        lat = 0;
        req_cycles = 0;
        got_rd = 'x;
        got_err = 'x;
        got_addr = 'x;
        @(negedge clk);
        start = 1'b1;
        addr = a;
        DEType = t;
        bus_ack = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (valid) begin
                lat = c;
                got_rd = rdata;
                got_err = err;
                break;
            end
            if (bus_req) begin
                req_cycles++;
                got_addr = bus_addr;
                if (c == ack_k) begin
                    bus_ack = 1'b1;
                    bus_rdata = d;
                end
            end
        end
    endtask

    task automatic test_reset;
        #3 reset = 1'b0;
        #1;
        n_total++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req got %b want 0", bus_req); else n_pass++;
        n_total++; if (bus_addr !== 32'h0) $display("FAIL reset_bus_addr got %h want 0", bus_addr); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
        n_total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata); else n_pass++;
        n_total++; if (err !== 2'b00) $display("FAIL reset_err got %b want 00", err); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input logic [31:0] got_rd, input logic [1:0] got_err);
        exp_t e;
        n_total++;
        if (lat !== exp_lat) $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
        else n_pass++;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s_scoreboard got empty want entry", name);
        end else begin
            e = sb.pop_front();
            n_total++;
            if (got_rd !== e.rd) $display("FAIL %s_rdata got %h want %h", name, got_rd, e.rd);
            else n_pass++;
            n_total++;
            if (got_err !== e.er) $display("FAIL %s_err got %b want %b", name, got_err, e.er);
            else n_pass++;
        end
        last_rd = got_rd;
        last_err = got_err;
    endtask

    task automatic test_lb(input string name);
        int lat, rq;
        logic [31:0] rd, ba;
        logic [1:0] er;
        sb.push_back('{rd: 32'hFFFF_FF80, er: 2'b00});
        do_load(3'b011, 32'h0000_1003, 32'h80FF_1234, 1, lat, rq, rd, er, ba);
        check_result(name, lat, 2, rd, er);
        n_total++; if (rq !== 1) $display("FAIL %s_req_cycles got %0d want 1", name, rq); else n_pass++;
        n_total++; if (ba !== 32'h0000_1000) $display("FAIL %s_bus_addr got %h want 00001000", name, ba); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL %s_after got busy=%b valid=%b want 0 0", name, busy, valid); else n_pass++;
        n_total++; if (bus_addr !== 32'h0000_1000) $display("FAIL %s_addr_hold got %h want 00001000", name, bus_addr); else n_pass++;
    endtask

    task automatic test_halfword;
        int lat, rq;
        logic [31:0] rd, ba;
        logic [1:0] er;
        sb.push_back('{rd: 32'h0000_8001, er: 2'b00});
        do_load(3'b100, 32'h0000_2002, 32'h8001_7FFF, 3, lat, rq, rd, er, ba);
        check_result("lhu", lat, 4, rd, er);
        n_total++; if (rq !== 3) $display("FAIL lhu_req_cycles got %0d want 3", rq); else n_pass++;
        sb.push_back('{rd: 32'h0000_7FFF, er: 2'b00});
        do_load(3'b101, 32'h0000_2000, 32'h8001_7FFF, 3, lat, rq, rd, er, ba);
        check_result("lh", lat, 4, rd, er);
    endtask

    task automatic test_misaligned;
        int lat, rq;
        logic [31:0] rd, ba;
        logic [1:0] er;
        sb.push_back('{rd: 32'h0, er: 2'b01});
        do_load(3'b001, 32'h0000_3002, 32'hFFFF_FFFF, 1, lat, rq, rd, er, ba);
        check_result("lw_mis", lat, 1, rd, er);
        n_total++; if (rq !== 0) $display("FAIL lw_mis_req_cycles got %0d want 0", rq); else n_pass++;
        sb.push_back('{rd: 32'h0, er: 2'b01});
        do_load(3'b111, 32'h0000_3000, 32'hFFFF_FFFF, 1, lat, rq, rd, er, ba);
        check_result("bad_type", lat, 1, rd, er);
        sb.push_back('{rd: 32'h0, er: 2'b01});
        do_load(3'b101, 32'h0000_3001, 32'hFFFF_FFFF, 1, lat, rq, rd, er, ba);
        check_result("lh_mis", lat, 1, rd, er);
    endtask

    task automatic test_timeout;
        int lat, rq;
        logic [31:0] rd, ba;
        logic [1:0] er;
        sb.push_back('{rd: 32'h0, er: 2'b10});
        do_load(3'b001, 32'h0000_4000, 32'h1234_5678, 0, lat, rq, rd, er, ba);
        check_result("timeout", lat, 17, rd, er);
        n_total++; if (rq !== 16) $display("FAIL timeout_req_cycles got %0d want 16", rq); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL timeout_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_ack_idle;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_ack = 1'b1;
            bus_rdata = 32'hA5A5_A5A5;
        end
        @(negedge clk);
        bus_ack = 1'b0;
        n_total++; if (valid !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0)
            $display("FAIL ack_idle got valid=%b busy=%b req=%b want 0 0 0", valid, busy, bus_req);
        else n_pass++;
    endtask

    task automatic test_flush;
        exp_t e;
        @(negedge clk);
        start = 1'b1; addr = 32'h0000_5000; DEType = 3'b001;
        @(negedge clk);
        start = 1'b0;
        n_total++; if (bus_req !== 1'b1) $display("FAIL flush_req_c1 got %b want 1", bus_req); else n_pass++;
        @(negedge clk);
        Req = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        Req = 1'b0; bus_ack = 1'b0;
        n_total++; if (busy !== 1'b0 || bus_req !== 1'b0 || valid !== 1'b0)
            $display("FAIL flush_c3 got busy=%b req=%b valid=%b want 0 0 0", busy, bus_req, valid);
        else n_pass++;
        n_total++; if (rdata !== last_rd || err !== last_err)
            $display("FAIL flush_hold got %h/%b want %h/%b", rdata, err, last_rd, last_err);
        else n_pass++;
        start = 1'b1; addr = 32'h0000_6001; DEType = 3'b010;
        sb.push_back('{rd: 32'h0000_00AB, er: 2'b00});
        @(negedge clk);
        start = 1'b0;
        n_total++; if (bus_req !== 1'b1 || valid !== 1'b0)
            $display("FAIL flush_reissue_c4 got req=%b valid=%b want 1 0", bus_req, valid);
        else n_pass++;
        bus_ack = 1'b1; bus_rdata = 32'h1234_AB56;
        @(negedge clk);
        bus_ack = 1'b0;
        n_total++; if (valid !== 1'b1) $display("FAIL flush_reissue_valid got %b want 1", valid); else n_pass++;
        e = sb.pop_front();
        n_total++; if (rdata !== e.rd || err !== e.er)
            $display("FAIL flush_reissue_data got %h/%b want %h/%b", rdata, err, e.rd, e.er);
        else n_pass++;
        last_rd = rdata;
        last_err = err;
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk);
        start = 1'b1; addr = 32'h0000_7000; DEType = 3'b001;
        @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_total++; if (bus_req !== 1'b0 || busy !== 1'b0 || valid !== 1'b0)
            $display("FAIL rst_mid_ctrl got req=%b busy=%b valid=%b want 0 0 0", bus_req, busy, valid);
        else n_pass++;
        n_total++; if (bus_addr !== 32'h0 || rdata !== 32'h0 || err !== 2'b00)
            $display("FAIL rst_mid_data got addr=%h rdata=%h err=%b want 0 0 0", bus_addr, rdata, err);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        test_lb("lb_after_rst");
    endtask

    task automatic test_back_to_back;
        int lat, rq, k;
        logic [31:0] rd, ba, a, d;
        logic [1:0] er;
        logic [2:0] t;
        logic mis;
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            t = 3'($urandom_range(0, 7));
            a = $urandom;
            d = $urandom;
            k = $urandom_range(1, 5);
            model(t, a, d, e, mis);
            sb.push_back(e);
            do_load(t, a, d, k, lat, rq, rd, er, ba);
            check_result("rand", lat, mis ? 1 : k + 1, rd, er);
            n_total++;
            if (rq !== (mis ? 0 : k)) $display("FAIL rand_req_cycles got %0d want %0d", rq, mis ? 0 : k);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lb("lb");
        test_misaligned();
        test_timeout();
        test_ack_idle();
        test_halfword();
        test_flush();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
